// File: rtl/uart_cmd_master.sv
// Host-side initiator for the byte-level UART command protocol (WRITE/READ/SWRST/RUN).
// Define UART_MST_TIMEOUT_EN to let a READ abort after TIMEOUT_CYC idle receive cycles.
//
// state       | meaning
// S_IDLE      | ready for a request
// S_SEND_CMD  | issue opcode byte
// S_SEND_ADDR | issue address byte
// S_SEND_DATA | issue NBYTES payload bytes, LSB first
// S_RECV_DATA | collect NBYTES reply bytes, MSB first
// S_DONE      | one-cycle response pulse
module uart_cmd_master #(
  parameter int DATA_W      = 304,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [7:0]        req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [7:0]        tx_byte,
  output logic              tx_byte_en,
  input  logic              tx_busy,
  input  logic [7:0]        rx_byte,
  input  logic              rx_byte_en,
  output logic              busy
);

  localparam int NBYTES = DATA_W / 8;
  localparam logic [5:0] LAST_IDX = 6'(NBYTES - 1);
  localparam logic [1:0] OP_READ  = 2'd1;

  if ((DATA_W % 8) != 0 || DATA_W < 16 || NBYTES > 63 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("uart_cmd_master: unsupported DATA_W/TIMEOUT_CYC");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_CMD, S_SEND_ADDR, S_SEND_DATA, S_RECV_DATA, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        op_q;
  logic [7:0]        addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [5:0]        cnt;
  logic              strb_d1, strb_d2;
  logic [7:0]        tx_byte_q;
  logic [7:0]        byte_sel;
  logic              can_tx, fire, accept, tmo_hit;

  // Two-cycle strobe guard hides the transmitter's busy-rise latency.
  assign can_tx     = !tx_busy && !strb_d1 && !strb_d2;
  assign accept     = req_valid && (state == S_IDLE);
  assign req_ready  = (state == S_IDLE);
  assign busy       = ~req_ready;
  assign tx_byte_en = fire && rst_n;
  assign tx_byte    = tx_byte_en ? byte_sel : tx_byte_q;
  assign rsp_valid  = (state == S_DONE) && rst_n;
  assign rsp_rdata  = rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    byte_sel  = 8'h00;
    case (state)
      S_IDLE: if (req_valid) state_nxt = S_SEND_CMD;
      S_SEND_CMD: begin
        byte_sel = {{2'b00, op_q} + 4'd1, 4'h0};
        if (can_tx) begin
          fire      = 1'b1;
          state_nxt = op_q[1] ? S_DONE : S_SEND_ADDR;
        end
      end
      S_SEND_ADDR: begin
        byte_sel = addr_q;
        if (can_tx) begin
          fire      = 1'b1;
          state_nxt = (op_q == OP_READ) ? S_RECV_DATA : S_SEND_DATA;
        end
      end
      S_SEND_DATA: begin
        byte_sel = wdata_q[7:0];
        if (can_tx) begin
          fire = 1'b1;
          if (cnt == LAST_IDX) state_nxt = S_DONE;
        end
      end
      S_RECV_DATA: begin
        if (rx_byte_en && cnt == LAST_IDX) state_nxt = S_DONE;
        else if (tmo_hit)                  state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt       <= '0;
      strb_d1   <= 1'b0;
      strb_d2   <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      strb_d1   <= tx_byte_en;
      strb_d2   <= strb_d1;
      tx_byte_q <= tx_byte;
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        if (req_op == OP_READ) rdata_q <= '0;
      end
      if (state == S_SEND_ADDR) cnt <= '0;
      if (state == S_SEND_DATA && fire) begin
        wdata_q <= wdata_q >> 8;
        cnt     <= cnt + 6'd1;
      end
      if (state == S_RECV_DATA && rx_byte_en) begin
        rdata_q <= {rdata_q[DATA_W-9:0], rx_byte};
        cnt     <= cnt + 6'd1;
      end
    end
  end

`ifdef UART_MST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          timeout_q;

  assign tmo_hit     = (state == S_RECV_DATA) && !rx_byte_en && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign rsp_timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != S_RECV_DATA || rx_byte_en) tmo_cnt <= '0;
      else                                    tmo_cnt <= tmo_cnt + TW'(1);
      if (accept)       timeout_q <= 1'b0;
      else if (tmo_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

endmodule
